mem_byte_rmw: RTL and testbench
===============================

Name: mem_byte_rmw

Overview:
- Memory-side responder for the CPU data port. It receives lane-aligned store data plus a byte-enable mask, and returns full 32-bit load words.
- Sits between the datapath's memory interface and a word-only physical memory (pmem) that has no byte-write capability.
- Full-word writes and reads pass straight through to pmem.
- Partial writes are done as a read-modify-write (RMW) sequence.
- Keeps a saturating count of RMW operations for performance monitoring.

Parameters:
- ADDR_W, 32, byte-address width of both the CPU port and the pmem port.
- CNT_W, 16, width of the RMW performance counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- mem_read  in  1  CPU read request; level, held until mem_resp.
- mem_write  in  1  CPU write request; level, held until mem_resp.
- mem_address  in  ADDR_W  CPU byte address; bits [1:0] ignored.
- mem_wdata  in  32  lane-aligned store data (byte k on bits [8k+7:8k]).
- mem_byte_enable  in  4  write lane mask; bit k enables byte k.
- mem_rdata  out  32  full word returned for reads.
- mem_resp  out  1  one-cycle completion pulse.
- pmem_read  out  1  pmem read strobe; held until pmem_resp.
- pmem_write  out  1  pmem write strobe; held until pmem_resp.
- pmem_address  out  ADDR_W  word address: {req_addr[ADDR_W-1:2], 2'b00}.
- pmem_wdata  out  32  word to write.
- pmem_rdata  in  32  pmem read data; valid when pmem_resp=1.
- pmem_resp  in  1  pmem completion; one-cycle pulse.
- rmw_count  out  CNT_W  number of completed RMW writes; saturates at all-ones.

Behaviour:
- Reset: while rst_n=0, the block is held in reset.
  - State is IDLE.
  - mem_resp, pmem_read and pmem_write are 0.
  - mem_rdata, pmem_wdata, rmw_count and all latched request registers are 0.
  - Reset asserted mid-transaction aborts it immediately, with no response and no further pmem strobe.
- States: IDLE, RD, WR, RMW_RD, RMW_WR, DONE.
- IDLE:
  - On a cycle with mem_write=1 or mem_read=1, latch address, wdata and byte_enable.
  - If both are asserted, write takes priority and the read is dropped; this combination is illegal for requesters.
  - Read goes to RD.
  - Write with byte_enable=4'hF goes to WR.
  - Write with byte_enable=0 goes to DONE with no pmem access.
  - Any other write mask goes to RMW_RD.
- RD:
  - pmem_read=1.
  - On pmem_resp: mem_rdata <= pmem_rdata, then go to DONE.
- WR:
  - pmem_write=1 with pmem_wdata = latched wdata.
  - On pmem_resp, go to DONE.
- RMW_RD:
  - pmem_read=1.
  - On pmem_resp, register the merged word: byte k = be[k] ? wdata byte k : pmem_rdata byte k.
  - Then go to RMW_WR.
- RMW_WR:
  - pmem_write=1 with pmem_wdata = merged word.
  - On pmem_resp: increment rmw_count (unless saturated), then go to DONE.
- DONE:
  - mem_resp=1 for exactly one cycle, then return to IDLE.
  - Requests are not sampled in DONE. A request still high in the following IDLE cycle is treated as a new request.
- Request handling:
  - Inputs are used only from the latched copy; changes to or deassertion of mem_* after the IDLE cycle have no effect.
  - pmem_address is stable for the whole transaction.
- Strobes and data:
  - pmem_read and pmem_write are never asserted together.
  - Each strobe drops in the cycle after pmem_resp.
  - mem_rdata holds its value until the next read completes; writes leave it unchanged.
- Latency: with pmem_resp arriving N cycles after the strobe rises (N>=1), mem_resp is asserted:
  - read and full write: N+2 cycles after the request is seen;
  - RMW: 2N+3 cycles after;
  - zero-mask write: 1 cycle after.
- pmem_resp seen outside RD, WR, RMW_RD or RMW_WR is ignored.

Test Plan:
- Read: mem_address=0x104, pmem returns 0xDEADBEEF with N=2 -> pmem_address=0x104, mem_rdata=0xDEADBEEF, mem_resp at cycle 4, pmem_write never asserted.
- Full write: mem_address=0x20, wdata=0x11223344, be=0xF -> exactly one pmem_write with pmem_wdata=0x11223344, no pmem_read, rmw_count unchanged.
- RMW byte: old word 0xAABBCCDD at 0x40, store with mem_address=0x42, wdata=0x00EE0000, be=0x4 -> pmem_read then pmem_write of 0xAAEECCDD to 0x40, rmw_count +1.
- Zero mask: be=0x0 -> mem_resp 1 cycle after the request, no pmem strobe.
- Reset mid-RMW: rst_n low during RMW_WR -> all outputs 0 at once, no mem_resp. After release, a new read completes normally.
- Saturation: CNT_W=2, five RMW writes -> rmw_count sequence 1,2,3,3,3. Back-to-back requests held high -> second request starts the cycle after DONE.

Source files
------------

// File: rtl/mem_byte_rmw.sv
// Byte-lane store front end for a word-only memory: full words pass through,
// and partial stores become a read-modify-write sequence with a saturating RMW counter.
//
// state  | meaning
// IDLE   | waiting for mem_read / mem_write, latches the request
// RD     | pmem read in flight for a CPU load
// WR     | pmem write of a full word
// RMW_RD | reading the old word to merge the enabled lanes into
// RMW_WR | writing the merged word back
// DONE   | one-cycle mem_resp
module mem_byte_rmw #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_address,
  input  logic [31:0]       mem_wdata,
  input  logic [3:0]        mem_byte_enable,
  output logic [31:0]       mem_rdata,
  output logic              mem_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [31:0]       pmem_wdata,
  input  logic [31:0]       pmem_rdata,
  input  logic              pmem_resp,
  output logic [CNT_W-1:0]  rmw_count
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD     = 3'd1,
    WR     = 3'd2,
    RMW_RD = 3'd3,
    RMW_WR = 3'd4,
    DONE   = 3'd5
  } state_e;

  state_e             state_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [31:0]        wdata_q;
  logic [3:0]         be_q;
  logic [31:0]        rdata_q;
  logic [31:0]        pmem_wdata_q;
  logic               mem_resp_q;
  logic               pmem_read_q;
  logic               pmem_write_q;
  logic [CNT_W-1:0]   rmw_count_q;
  logic [31:0]        merged_d;

  // Enabled lanes come from the latched store data, the rest from the old word.
  always_comb begin
    merged_d = pmem_rdata;
    for (int k = 0; k < 4; k++) begin
      if (be_q[k]) merged_d[8*k +: 8] = wdata_q[8*k +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      rdata_q      <= '0;
      pmem_wdata_q <= '0;
      mem_resp_q   <= 1'b0;
      pmem_read_q  <= 1'b0;
      pmem_write_q <= 1'b0;
      rmw_count_q  <= '0;
    end else begin
      mem_resp_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (mem_write || mem_read) begin
            addr_q  <= mem_address;
            wdata_q <= mem_wdata;
            be_q    <= mem_byte_enable;
          end
          // Write wins if both are raised; the read is simply dropped.
          if (mem_write) begin
            if (mem_byte_enable == 4'hF) begin
              state_q      <= WR;
              pmem_write_q <= 1'b1;
              pmem_wdata_q <= mem_wdata;
            end else if (mem_byte_enable == 4'h0) begin
              state_q    <= DONE;
              mem_resp_q <= 1'b1;
            end else begin
              state_q     <= RMW_RD;
              pmem_read_q <= 1'b1;
            end
          end else if (mem_read) begin
            state_q     <= RD;
            pmem_read_q <= 1'b1;
          end
        end
        RD: begin
          if (pmem_resp) begin
            rdata_q     <= pmem_rdata;
            pmem_read_q <= 1'b0;
            state_q     <= DONE;
            mem_resp_q  <= 1'b1;
          end
        end
        WR: begin
          if (pmem_resp) begin
            pmem_write_q <= 1'b0;
            state_q      <= DONE;
            mem_resp_q   <= 1'b1;
          end
        end
        RMW_RD: begin
          if (pmem_resp) begin
            pmem_wdata_q <= merged_d;
            pmem_read_q  <= 1'b0;
            pmem_write_q <= 1'b1;
            state_q      <= RMW_WR;
          end
        end
        RMW_WR: begin
          if (pmem_resp) begin
            pmem_write_q <= 1'b0;
            if (rmw_count_q != {CNT_W{1'b1}}) rmw_count_q <= rmw_count_q + CNT_W'(1);
            state_q    <= DONE;
            mem_resp_q <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q      <= IDLE;
          pmem_read_q  <= 1'b0;
          pmem_write_q <= 1'b0;
        end
      endcase
    end
  end

  assign mem_rdata    = rdata_q;
  assign mem_resp     = mem_resp_q;
  assign pmem_read    = pmem_read_q;
  assign pmem_write   = pmem_write_q;
  assign pmem_wdata   = pmem_wdata_q;
  assign pmem_address = addr_q & ~{{(ADDR_W-2){1'b0}}, 2'b11};
  assign rmw_count    = rmw_count_q;

endmodule

// File: tb/tb_mem_byte_rmw.sv
// Directed bench for mem_byte_rmw: a latency-programmable pmem responder and
// two DUTs (default counter width and a 2-bit counter) sharing all stimulus.
module tb_mem_byte_rmw;

  logic        clk;
  logic        rst_n;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_rdata;
  logic        mem_resp;
  logic        pmem_read;
  logic        pmem_write;
  logic [31:0] pmem_address;
  logic [31:0] pmem_wdata;
  logic [31:0] pmem_rdata;
  logic        pmem_resp;
  logic [15:0] rmw_count;

  logic [31:0] s_mem_rdata;
  logic        s_mem_resp;
  logic        s_pmem_read;
  logic        s_pmem_write;
  logic [31:0] s_pmem_address;
  logic [31:0] s_pmem_wdata;
  logic [1:0]  s_rmw_count;

  mem_byte_rmw #(.ADDR_W(32), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .rmw_count(rmw_count)
  );

  mem_byte_rmw #(.ADDR_W(32), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
    .mem_rdata(s_mem_rdata), .mem_resp(s_mem_resp),
    .pmem_read(s_pmem_read), .pmem_write(s_pmem_write), .pmem_address(s_pmem_address),
    .pmem_wdata(s_pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .rmw_count(s_rmw_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  // pmem model state: contents are preloaded by the main sequence only
  logic [31:0] pm [0:255];
  int          pm_lat = 2;
  int          age = 0;
  int          rd_cyc = 0, wr_cyc = 0, overlap = 0;
  int          rd_done = 0, wr_done = 0, resp_cnt = 0;
  logic [31:0] last_rd_addr = '0, last_wr_addr = '0, last_wr_data = '0;

  initial begin
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(negedge clk);
      pmem_resp = 1'b0;
      if (mem_resp) resp_cnt++;
      if (!rst_n) begin
        age = 0;
      end else begin
        if (pmem_read) rd_cyc++;
        if (pmem_write) wr_cyc++;
        if (pmem_read && pmem_write) overlap++;
        if (pmem_read || pmem_write) begin
          age++;
          if (age == pm_lat + 1) begin
            age = 0;
            pmem_resp = 1'b1;
            if (pmem_read) begin
              pmem_rdata   = pm[pmem_address[9:2]];
              last_rd_addr = pmem_address;
              rd_done++;
            end else begin
              last_wr_addr = pmem_address;
              last_wr_data = pmem_wdata;
              wr_done++;
            end
          end
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called mid-cycle in IDLE; returns mid-cycle in the following IDLE.
  task automatic do_req(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] be, output int lat);
    mem_read        = rd;
    mem_write       = wr;
    mem_address     = addr;
    mem_wdata       = wd;
    mem_byte_enable = be;
    lat = -1;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (mem_resp) begin
        lat = c;
        break;
      end
    end
    mem_read  = 1'b0;
    mem_write = 1'b0;
    @(negedge clk);
  endtask

  int lat;
  int rc0, wc0, rd0, wd0, r0;
  int sat_exp [5];
  int found, t1, t2, pr1, pr2, cyc;

  initial begin
    sat_exp = '{1, 2, 3, 3, 3};
    rst_n = 1'b0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    mem_address = 32'h0000_0FFF;
    mem_wdata = 32'hFFFF_FFFF;
    mem_byte_enable = 4'hF;
    pm[65] = 32'hDEAD_BEEF;   // 0x104
    pm[16] = 32'hAABB_CCDD;   // 0x40
    pm[17] = 32'h1234_5678;   // 0x44
    pm[32] = 32'h1111_1111;   // 0x80
    repeat (3) @(negedge clk);

    check("rst_mem_resp", mem_resp, 0);
    check("rst_pmem_read", pmem_read, 0);
    check("rst_pmem_write", pmem_write, 0);
    check("rst_mem_rdata", mem_rdata, 0);
    check("rst_pmem_wdata", pmem_wdata, 0);
    check("rst_pmem_address", pmem_address, 0);
    check("rst_rmw_count", rmw_count, 0);

    mem_byte_enable = 4'h0;
    rst_n = 1'b1;
    @(negedge clk);

    // Read, N=2
    rc0 = rd_cyc; wc0 = wr_cyc; rd0 = rd_done;
    do_req(1'b1, 1'b0, 32'h104, 32'h0, 4'h0, lat);
    check("rd_latency", lat, 4);
    check("rd_data", mem_rdata, 32'hDEAD_BEEF);
    check("rd_pmem_addr", last_rd_addr, 32'h104);
    check("rd_no_write", wr_cyc - wc0, 0);
    check("rd_strobe_cycles", rd_cyc - rc0, 3);
    check("rd_one_access", rd_done - rd0, 1);

    // Full-word write
    rc0 = rd_cyc; wd0 = wr_done;
    do_req(1'b0, 1'b1, 32'h20, 32'h1122_3344, 4'hF, lat);
    check("wr_latency", lat, 4);
    check("wr_count", wr_done - wd0, 1);
    check("wr_data", last_wr_data, 32'h1122_3344);
    check("wr_addr", last_wr_addr, 32'h20);
    check("wr_no_read", rd_cyc - rc0, 0);
    check("wr_rmw_count", rmw_count, 0);
    check("wr_rdata_kept", mem_rdata, 32'hDEAD_BEEF);

    // Single-byte RMW, N=2
    rd0 = rd_done; wd0 = wr_done;
    do_req(1'b0, 1'b1, 32'h42, 32'h00EE_0000, 4'h4, lat);
    check("rmw1_latency", lat, 7);
    check("rmw1_reads", rd_done - rd0, 1);
    check("rmw1_writes", wr_done - wd0, 1);
    check("rmw1_rd_addr", last_rd_addr, 32'h40);
    check("rmw1_wr_addr", last_wr_addr, 32'h40);
    check("rmw1_data", last_wr_data, 32'hAAEE_CCDD);
    check("rmw1_count", rmw_count, 1);
    check("rmw1_count_sat", s_rmw_count, 1);

    // Two-lane RMW, N=3
    pm_lat = 3;
    do_req(1'b0, 1'b1, 32'h44, 32'hA1B2_C3D4, 4'h9, lat);
    check("rmw2_latency", lat, 9);
    check("rmw2_data", last_wr_data, 32'hA134_56D4);
    check("rmw2_count", rmw_count, 2);
    pm_lat = 2;

    // Zero mask
    rc0 = rd_cyc; wc0 = wr_cyc;
    do_req(1'b0, 1'b1, 32'h40, 32'hFFFF_FFFF, 4'h0, lat);
    check("zero_latency", lat, 1);
    check("zero_no_read", rd_cyc - rc0, 0);
    check("zero_no_write", wr_cyc - wc0, 0);
    check("zero_count", rmw_count, 2);

    // Read and write together: write wins
    rc0 = rd_cyc;
    do_req(1'b1, 1'b1, 32'h60, 32'h5A5A_5A5A, 4'hF, lat);
    check("both_latency", lat, 4);
    check("both_no_read", rd_cyc - rc0, 0);
    check("both_wr_data", last_wr_data, 32'h5A5A_5A5A);
    check("both_rdata_kept", mem_rdata, 32'hDEAD_BEEF);

    // Reset in the middle of RMW_WR
    pm_lat = 5;
    r0 = resp_cnt; wd0 = wr_done;
    mem_write = 1'b1; mem_address = 32'h49; mem_wdata = 32'h0000_7700; mem_byte_enable = 4'h2;
    found = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (pmem_write) begin
        found = 1;
        break;
      end
    end
    check("abort_reached_rmw_wr", found, 1);
    rst_n = 1'b0;
    mem_write = 1'b0;
    #1;
    check("abort_pmem_write", pmem_write, 0);
    check("abort_pmem_read", pmem_read, 0);
    check("abort_mem_resp", mem_resp, 0);
    check("abort_pmem_wdata", pmem_wdata, 0);
    check("abort_pmem_address", pmem_address, 0);
    check("abort_mem_rdata", mem_rdata, 0);
    check("abort_rmw_count", rmw_count, 0);
    check("abort_rmw_count_sat", s_rmw_count, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("abort_idle_strobes", {pmem_read, pmem_write}, 2'b00);
    check("abort_no_resp", resp_cnt - r0, 0);
    check("abort_no_write_done", wr_done - wd0, 0);
    pm_lat = 2;
    do_req(1'b1, 1'b0, 32'h104, 32'h0, 4'h0, lat);
    check("post_rst_rd_latency", lat, 4);
    check("post_rst_rd_data", mem_rdata, 32'hDEAD_BEEF);

    // Counter saturation, N=1
    pm_lat = 1;
    for (int i = 1; i <= 5; i++) begin
      do_req(1'b0, 1'b1, 32'h81, 32'(i), 4'h1, lat);
      check("sat_latency", lat, 5);
      check("sat_count_2bit", s_rmw_count, sat_exp[i-1]);
      check("sat_count_16bit", rmw_count, i);
    end
    check("sat_last_data", last_wr_data, 32'h1111_1105);

    // Back-to-back reads with mem_read held high
    pm_lat = 2;
    rd0 = rd_done;
    t1 = -1; t2 = -1; pr1 = -1; pr2 = -1;
    mem_read = 1'b1; mem_address = 32'h104;
    cyc = 0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      cyc = c;
      if (t1 >= 0 && c == t1 + 1) pr1 = int'(pmem_read);
      if (t1 >= 0 && c == t1 + 2) pr2 = int'(pmem_read);
      if (mem_resp) begin
        if (t1 < 0) t1 = c;
        else begin
          t2 = c;
          break;
        end
      end
    end
    mem_read = 1'b0;
    @(negedge clk);
    check("b2b_first_resp", t1, 4);
    check("b2b_gap", t2 - t1, 5);
    check("b2b_idle_no_strobe", pr1, 0);
    check("b2b_restart_strobe", pr2, 1);
    check("b2b_reads", rd_done - rd0, 2);

    check("strobe_overlap", overlap, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
